// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB from the
// latched IR opcode/funct and drives every datapath select and write enable.
module mc_ctrl #(
  parameter bit UNKNOWN_AS_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic is_rtype, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_known;

  assign is_rtype = (opcode == 6'h00);
  assign is_addu  = is_rtype && (funct == 6'h21);
  assign is_subu  = is_rtype && (funct == 6'h23);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_nop   = is_rtype && (funct == 6'h00);
  assign is_ori   = (opcode == 6'h0D);
  assign is_lui   = (opcode == 6'h0F);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_beq   = (opcode == 6'h04);
  assign is_j     = (opcode == 6'h02);
  assign is_jal   = (opcode == 6'h03);
  assign is_known = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui |
                    is_lw | is_sw | is_beq | is_j | is_jal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d  = state_q;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 3'd0;
    RegDst   = 2'd0;
    WDSel    = 2'd0;
    NPCOp    = 2'd0;
    retire   = 1'b0;
    illegal  = 1'b0;

    // Extender mode depends only on the latched opcode, so it stays stable
    // for the whole instruction once DECODE is reached.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})
      EXTOp = is_ori | is_lui;

    unique case (state_q)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        NPCOp   = 2'd0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          PCWr    = 1'b1;
          NPCOp   = 2'd2;
          retire  = 1'b1;
          state_d = S_FETCH;
          if (is_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            WDSel    = 2'd2;
          end
        end else if (is_jr) begin
          PCWr    = 1'b1;
          NPCOp   = 2'd3;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_nop) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!is_known) begin
          if (UNKNOWN_AS_NOP) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_HALT;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        if (is_subu) begin
          ALUOp = 3'd1;
        end else if (is_ori) begin
          ALUOp  = 3'd2;
          ALUSrc = 1'b1;
        end else if (is_lui) begin
          ALUOp  = 3'd3;
          ALUSrc = 1'b1;
        end else if (is_lw || is_sw) begin
          ALUSrc  = 1'b1;
          state_d = S_MEM;
        end else if (is_beq) begin
          ALUOp   = 3'd1;
          PCWr    = zero;
          NPCOp   = 2'd1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          MemWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype ? 2'd1 : 2'd0;
        WDSel    = is_lw ? 2'd1 : 2'd0;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts any in-flight instruction: suppress every side effect.
    if (reset) begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected control vectors are queued for
// each instruction and compared against the DUT outputs cycle by cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr, IRWr, RegWrite, MemWrite, EXTOp, ALUSrc;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, WDSel, NPCOp;
  logic [2:0] state;
  logic       retire, illegal;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       tag;
    logic [19:0] exp;
    logic [19:0] mask;
  } item_t;

  item_t q[$];

  // Bit order: pcwr irwr rw mw ext als aluop[3] regdst[2] wdsel[2] npc[2] st[3] ret ill
  localparam logic [19:0] M_ALL   = 20'hFFFFF;
  localparam logic [19:0] M_EN    = 20'hF0003;
  localparam logic [19:0] M_NOEXT = 20'hF7FFF;

  mc_ctrl #(.UNKNOWN_AS_NOP(1'b0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegDst(RegDst),
    .WDSel(WDSel), .NPCOp(NPCOp), .state(state), .retire(retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] e(
    input logic pc, input logic ir, input logic rw, input logic mw,
    input logic ex, input logic as, input logic [2:0] op, input logic [1:0] rd,
    input logic [1:0] wd, input logic [1:0] np, input logic [2:0] st,
    input logic rt, input logic il);
    return {pc, ir, rw, mw, ex, as, op, rd, wd, np, st, rt, il};
  endfunction

  task automatic push(input string tag, input logic [19:0] ex, input logic [19:0] m);
    item_t it;
    it.tag  = tag;
    it.exp  = ex;
    it.mask = m;
    q.push_back(it);
  endtask

  task automatic push_fetch(input string tag);
    push(tag, e(1,1,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd0,0,0), M_NOEXT);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  // One queued expectation is consumed per clock cycle, sampled on the falling edge.
  task automatic drain();
    item_t       it;
    logic [19:0] obs;
    while (q.size() > 0) begin
      @(negedge clk);
      it  = q.pop_front();
      obs = {PCWr, IRWr, RegWrite, MemWrite, EXTOp, ALUSrc, ALUOp, RegDst,
             WDSel, NPCOp, state, retire, illegal};
      total++;
      assert ((obs & it.mask) === (it.exp & it.mask)) else begin
        bad++;
        $error("FAIL %s observed=%05h expected=%05h mask=%05h",
               it.tag, obs & it.mask, it.exp & it.mask, it.mask);
      end
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    reset = 1'b1;
    set_instr(6'h00, 6'h00, 1'b0);
    push("reset_c0", '0, M_EN);
    push("reset_c1", '0, M_EN);
    drain();
    reset = 1'b0;

    // ori: 4 cycles, zero-extend
    set_instr(6'h0D, 6'h00, 1'b0);
    push_fetch("ori_F");
    push("ori_D", e(0,0,0,0,1,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("ori_E", e(0,0,0,0,1,1,3'd2,2'd0,2'd0,2'd0,3'd2,0,0), M_ALL);
    push("ori_W", e(0,0,1,0,1,0,3'd0,2'd0,2'd0,2'd0,3'd4,1,0), M_ALL);
    drain();

    // lw: 5 cycles, sign-extend, DM data written back
    set_instr(6'h23, 6'h00, 1'b0);
    push_fetch("lw_F");
    push("lw_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("lw_E", e(0,0,0,0,0,1,3'd0,2'd0,2'd0,2'd0,3'd2,0,0), M_ALL);
    push("lw_M", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd3,0,0), M_ALL);
    push("lw_W", e(0,0,1,0,0,0,3'd0,2'd0,2'd1,2'd0,3'd4,1,0), M_ALL);
    drain();

    // sw: 4 cycles, single MemWrite in MEM
    set_instr(6'h2B, 6'h00, 1'b0);
    push_fetch("sw_F");
    push("sw_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("sw_E", e(0,0,0,0,0,1,3'd0,2'd0,2'd0,2'd0,3'd2,0,0), M_ALL);
    push("sw_M", e(0,0,0,1,0,0,3'd0,2'd0,2'd0,2'd0,3'd3,1,0), M_ALL);
    drain();

    // beq taken / not taken
    set_instr(6'h04, 6'h00, 1'b1);
    push_fetch("beqT_F");
    push("beqT_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("beqT_E", e(1,0,0,0,0,0,3'd1,2'd0,2'd0,2'd1,3'd2,1,0), M_ALL);
    drain();
    set_instr(6'h04, 6'h00, 1'b0);
    push_fetch("beqN_F");
    push("beqN_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("beqN_E", e(0,0,0,0,0,0,3'd1,2'd0,2'd0,2'd1,3'd2,1,0), M_ALL);
    drain();

    // jal, j, jr: 2 cycles each
    set_instr(6'h03, 6'h00, 1'b0);
    push_fetch("jal_F");
    push("jal_D", e(1,0,1,0,0,0,3'd0,2'd2,2'd2,2'd2,3'd1,1,0), M_ALL);
    drain();
    set_instr(6'h02, 6'h00, 1'b0);
    push_fetch("j_F");
    push("j_D", e(1,0,0,0,0,0,3'd0,2'd0,2'd0,2'd2,3'd1,1,0), M_ALL);
    drain();
    set_instr(6'h00, 6'h08, 1'b0);
    push_fetch("jr_F");
    push("jr_D", e(1,0,0,0,0,0,3'd0,2'd0,2'd0,2'd3,3'd1,1,0), M_ALL);
    drain();

    // nop retires in DECODE without any write
    set_instr(6'h00, 6'h00, 1'b0);
    push_fetch("nop_F");
    push("nop_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,1,0), M_ALL);
    drain();

    // addu / subu / lui
    set_instr(6'h00, 6'h21, 1'b0);
    push_fetch("addu_F");
    push("addu_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("addu_E", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd2,0,0), M_ALL);
    push("addu_W", e(0,0,1,0,0,0,3'd0,2'd1,2'd0,2'd0,3'd4,1,0), M_ALL);
    drain();
    set_instr(6'h00, 6'h23, 1'b0);
    push_fetch("subu_F");
    push("subu_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("subu_E", e(0,0,0,0,0,0,3'd1,2'd0,2'd0,2'd0,3'd2,0,0), M_ALL);
    push("subu_W", e(0,0,1,0,0,0,3'd0,2'd1,2'd0,2'd0,3'd4,1,0), M_ALL);
    drain();
    set_instr(6'h0F, 6'h00, 1'b0);
    push_fetch("lui_F");
    push("lui_D", e(0,0,0,0,1,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("lui_E", e(0,0,0,0,1,1,3'd3,2'd0,2'd0,2'd0,3'd2,0,0), M_ALL);
    push("lui_W", e(0,0,1,0,1,0,3'd0,2'd0,2'd0,2'd0,3'd4,1,0), M_ALL);
    drain();

    // sw aborted by reset while in MEM: no MemWrite, restart in FETCH
    set_instr(6'h2B, 6'h00, 1'b0);
    push_fetch("swR_F");
    push("swR_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    push("swR_E", e(0,0,0,0,0,1,3'd0,2'd0,2'd0,2'd0,3'd2,0,0), M_ALL);
    drain();
    reset = 1'b1;
    push("swR_Mrst", '0, M_EN);
    drain();
    reset = 1'b0;

    // unknown opcode halts and holds illegal until reset
    set_instr(6'h3F, 6'h00, 1'b0);
    push_fetch("ill_F");
    push("ill_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,0,0), M_ALL);
    for (int i = 0; i < 3; i++)
      push("ill_H", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd7,0,1), M_ALL);
    drain();
    reset = 1'b1;
    push("ill_rst", '0, M_EN);
    drain();
    reset = 1'b0;
    set_instr(6'h00, 6'h00, 1'b0);
    push_fetch("post_rst_F");
    push("post_rst_D", e(0,0,0,0,0,0,3'd0,2'd0,2'd0,2'd0,3'd1,1,0), M_ALL);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
